// File: rtl/itag_fill_ctrl_if.sv
// Bundle of fetch-miss, memory, data-bank, snoop and tag port-B signals around the I-cache fill controller.
// master = fill controller, slave = surrounding fetch/memory/bank logic.
interface itag_fill_ctrl_if #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LINE_ADDR_W = 6
);
  localparam int unsigned SUB_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 30 - SUB_W - LINE_ADDR_W;

  logic                   miss;
  logic [31:0]            miss_addr;
  logic                   mem_req;
  logic [31:0]            mem_addr;
  logic                   mem_ack;
  logic                   mem_rvalid;
  logic                   data_wen;
  logic [SUB_W-1:0]       data_word_idx;
  logic [WAYS-1:0]        data_way;
  logic                   snoop_valid;
  logic [31:0]            snoop_addr;
  logic                   snoop_ack;
  logic                   tagb_en;
  logic [WAYS-1:0]        tagb_wen;
  logic [LINE_ADDR_W-1:0] tagb_line;
  logic [TAG_W:0]         tagb_data;
  logic                   busy;
  logic                   fill_done;

  modport master (
    input  miss, miss_addr, mem_ack, mem_rvalid, snoop_valid, snoop_addr,
    output mem_req, mem_addr, data_wen, data_word_idx, data_way, snoop_ack,
           tagb_en, tagb_wen, tagb_line, tagb_data, busy, fill_done
  );

  modport slave (
    output miss, miss_addr, mem_ack, mem_rvalid, snoop_valid, snoop_addr,
    input  mem_req, mem_addr, data_wen, data_word_idx, data_way, snoop_ack,
           tagb_en, tagb_wen, tagb_line, tagb_data, busy, fill_done
  );
endinterface

// File: rtl/itag_fill_ctrl.sv
// I-cache miss sequencer: line fetch, victim selection, tag write on port B,
// with snoop invalidations arbitrated onto the same port.
module itag_fill_ctrl #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LINE_ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  itag_fill_ctrl_if.master   bus
);
  localparam int unsigned SUB_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = 30 - SUB_W - LINE_ADDR_W;
  localparam int unsigned LA_W  = 30 - SUB_W;
  localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_TAG_WR
  } state_t;

  state_t            state_q, state_d;
  logic [LA_W-1:0]   line_q, line_d;
  logic [SUB_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              poison_q, poison_d;

  logic              snoop_grant;
  logic [LA_W-1:0]   snoop_la;
  logic [LA_W-1:0]   miss_la;
  logic [WAYS-1:0]   victim_oh;
  logic              unused_low_bits;

  assign snoop_la        = bus.snoop_addr[31:SUB_W+2];
  assign miss_la         = bus.miss_addr[31:SUB_W+2];
  assign unused_low_bits = ^{bus.snoop_addr[SUB_W+1:0], bus.miss_addr[SUB_W+1:0]};
  // Port B belongs to the fill only during its single tag-write cycle.
  assign snoop_grant     = bus.snoop_valid && (state_q != S_TAG_WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      poison_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      poison_q <= poison_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    poison_d  = poison_q;

    victim_oh        = '0;
    victim_oh[ptr_q] = 1'b1;

    bus.mem_req       = 1'b0;
    bus.mem_addr      = '0;
    bus.data_wen      = 1'b0;
    bus.data_word_idx = cnt_q;
    bus.data_way      = '0;
    bus.snoop_ack     = 1'b0;
    bus.tagb_en       = 1'b0;
    bus.tagb_wen      = '0;
    bus.tagb_line     = '0;
    bus.tagb_data     = '0;
    bus.busy          = (state_q != S_IDLE);
    bus.fill_done     = 1'b0;

    if (snoop_grant) begin
      bus.snoop_ack = 1'b1;
      bus.tagb_en   = 1'b1;
      bus.tagb_wen  = '1;
      bus.tagb_line = bus.snoop_addr[SUB_W+2 +: LINE_ADDR_W];
      bus.tagb_data = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.miss) begin
          state_d  = S_REQ;
          line_d   = miss_la;
          cnt_d    = '0;
          // Entering REQ clears poison, except for a same-cycle snoop on the line being latched.
          poison_d = snoop_grant && (snoop_la == miss_la);
        end
      end
      S_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_q, {(SUB_W+2){1'b0}}};
        if (snoop_grant && (snoop_la == line_q)) poison_d = 1'b1;
        if (bus.mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        bus.data_way = victim_oh;
        if (snoop_grant && (snoop_la == line_q)) poison_d = 1'b1;
        if (bus.mem_rvalid) begin
          bus.data_wen = 1'b1;
          cnt_d        = cnt_q + SUB_W'(1);
          if (cnt_q == SUB_W'(LINE_WORDS - 1)) state_d = S_TAG_WR;
        end
      end
      S_TAG_WR: begin
        bus.tagb_en   = 1'b1;
        bus.tagb_wen  = victim_oh;
        bus.tagb_line = line_q[LINE_ADDR_W-1:0];
        bus.tagb_data = {~poison_q, line_q[LA_W-1:LINE_ADDR_W]};
        bus.fill_done = 1'b1;
        ptr_d         = (ptr_q == PTR_W'(WAYS - 1)) ? '0 : ptr_q + PTR_W'(1);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_itag_fill_ctrl.sv
// Scenario bench for itag_fill_ctrl: expected word indices and tag writes are queued
// when stimulus is driven and compared when the controller produces them.
module tb_itag_fill_ctrl;
  localparam int unsigned WAYS        = 2;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned LINE_ADDR_W = 6;

  typedef struct {
    logic [1:0]  wen;
    logic [5:0]  line;
    logic [22:0] data;
  } tagwr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  itag_fill_ctrl_if #(.WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .LINE_ADDR_W(LINE_ADDR_W)) bus ();

  itag_fill_ctrl #(.WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .LINE_ADDR_W(LINE_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          model_ptr = 0;
  tagwr_t      tag_q[$];
  int unsigned word_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.miss        = 1'b0;
    bus.miss_addr   = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = '0;
  endtask

  function automatic logic [72:0] all_outs();
    return {bus.mem_req, bus.mem_addr, bus.data_wen, bus.data_word_idx, bus.data_way,
            bus.snoop_ack, bus.tagb_en, bus.tagb_wen, bus.tagb_line, bus.tagb_data,
            bus.busy, bus.fill_done};
  endfunction

  // snoop_phase: -1 none, 0..3 with that returned word, 4 with the miss in IDLE, 5 in TAG_WR
  task automatic run_fill(input logic [31:0] addr, input int ack_delay, input int gap,
                          input int snoop_phase, input logic [31:0] saddr, input logic exp_valid);
    logic [1:0] way_oh;
    tagwr_t     exp_t;
    int unsigned exp_w;
    way_oh = 2'b01 << model_ptr;
    tag_q.push_back('{way_oh, addr[9:4], {exp_valid, addr[31:10]}});

    bus.miss      = 1'b1;
    bus.miss_addr = addr;
    if (snoop_phase == 4) begin
      bus.snoop_valid = 1'b1;
      bus.snoop_addr  = saddr;
    end
    sample();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got %b want 0", bus.busy);
    end
    if (snoop_phase == 4) begin
      checks++;
      if ({bus.snoop_ack, bus.tagb_wen, bus.tagb_data} !== {1'b1, 2'b11, 23'd0}) begin
        errors++; $display("FAIL idle_snoop got ack=%b wen=%b data=%h want ack=1 wen=11 data=0",
                           bus.snoop_ack, bus.tagb_wen, bus.tagb_data);
      end
    end
    tick();
    bus.miss        = 1'b0;
    bus.miss_addr   = $urandom;
    bus.snoop_valid = 1'b0;

    for (int i = 0; i <= ack_delay; i++) begin
      bus.mem_ack = (i == ack_delay);
      sample();
      checks++;
      if ({bus.mem_req, bus.busy, bus.mem_addr} !== {2'b11, addr[31:4], 4'h0}) begin
        errors++; $display("FAIL req_hold cyc=%0d got req=%b busy=%b addr=%h want req=1 busy=1 addr=%h",
                           i, bus.mem_req, bus.busy, bus.mem_addr, {addr[31:4], 4'h0});
      end
      tick();
    end
    bus.mem_ack = 1'b0;

    for (int w = 0; w < LINE_WORDS; w++) begin
      for (int g = 0; g < gap; g++) begin
        bus.mem_rvalid = 1'b0;
        sample();
        checks++;
        if (bus.data_wen !== 1'b0) begin
          errors++; $display("FAIL gap_wen word=%0d got %b want 0", w, bus.data_wen);
        end
        tick();
      end
      bus.mem_rvalid = 1'b1;
      word_q.push_back(w);
      if (snoop_phase == w) begin
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = saddr;
      end
      sample();
      checks++;
      if (bus.data_wen === 1'b1 && word_q.size() > 0) begin
        exp_w = word_q.pop_front();
        if ({bus.data_word_idx, bus.data_way} !== {exp_w[1:0], way_oh}) begin
          errors++; $display("FAIL word got idx=%0d way=%b want idx=%0d way=%b",
                             bus.data_word_idx, bus.data_way, exp_w, way_oh);
        end
      end else begin
        errors++; $display("FAIL word_wen got %b want 1", bus.data_wen);
      end
      if (snoop_phase == w) begin
        checks++;
        if ({bus.snoop_ack, bus.tagb_en, bus.tagb_wen, bus.tagb_line, bus.tagb_data} !==
            {1'b1, 1'b1, 2'b11, saddr[9:4], 23'd0}) begin
          errors++; $display("FAIL fill_snoop got ack=%b en=%b wen=%b line=%h data=%h want 1 1 11 %h 0",
                             bus.snoop_ack, bus.tagb_en, bus.tagb_wen, bus.tagb_line, bus.tagb_data, saddr[9:4]);
        end
      end
      tick();
      bus.mem_rvalid  = 1'b0;
      bus.snoop_valid = 1'b0;
    end

    if (snoop_phase == 5) begin
      bus.snoop_valid = 1'b1;
      bus.snoop_addr  = saddr;
    end
    sample();
    checks++;
    if ({bus.fill_done, bus.tagb_en, bus.busy} !== 3'b111) begin
      errors++; $display("FAIL tagwr_strobe got done=%b en=%b busy=%b want 111",
                         bus.fill_done, bus.tagb_en, bus.busy);
    end
    checks++;
    if (tag_q.size() > 0) begin
      exp_t = tag_q.pop_front();
      if ({bus.tagb_wen, bus.tagb_line, bus.tagb_data} !== {exp_t.wen, exp_t.line, exp_t.data}) begin
        errors++; $display("FAIL tagwr got wen=%b line=%h data=%h want wen=%b line=%h data=%h",
                           bus.tagb_wen, bus.tagb_line, bus.tagb_data, exp_t.wen, exp_t.line, exp_t.data);
      end
    end else begin
      errors++; $display("FAIL tagwr_queue got empty want entry");
    end
    if (snoop_phase == 5) begin
      checks++;
      if (bus.snoop_ack !== 1'b0) begin
        errors++; $display("FAIL tagwr_snoop_wait got ack=%b want 0", bus.snoop_ack);
      end
    end
    tick();
    model_ptr = (model_ptr + 1) % WAYS;

    sample();
    checks++;
    if ({bus.busy, bus.fill_done} !== 2'b00) begin
      errors++; $display("FAIL post_fill got busy=%b done=%b want 00", bus.busy, bus.fill_done);
    end
    if (snoop_phase == 5) begin
      checks++;
      if ({bus.snoop_ack, bus.tagb_wen, bus.tagb_line, bus.tagb_data} !== {1'b1, 2'b11, saddr[9:4], 23'd0}) begin
        errors++; $display("FAIL late_snoop got ack=%b wen=%b line=%h data=%h want 1 11 %h 0",
                           bus.snoop_ack, bus.tagb_wen, bus.tagb_line, bus.tagb_data, saddr[9:4]);
      end
    end
    tick();
    bus.snoop_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if (all_outs() !== 73'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    tick();
  endtask

  task automatic test_single_fill();
    run_fill(32'h0000_1040, 0, 0, -1, 32'h0, 1'b1);
  endtask

  task automatic test_rotation();
    // same set, different tag snoop must not poison the fill
    run_fill(32'h0000_2140, 0, 0, 1, 32'h0000_2540, 1'b1);
    run_fill(32'h0003_05F0, 0, 0, -1, 32'h0, 1'b1);
  endtask

  task automatic test_snoop_poison();
    run_fill(32'h0000_1040, 0, 0, 2, 32'h0000_1044, 1'b0);
  endtask

  task automatic test_snoop_tagwr();
    run_fill(32'h0000_1040, 0, 0, 5, 32'h0000_3000, 1'b1);
  endtask

  task automatic test_delayed_ack();
    run_fill(32'hFFFF_FFFC, 5, 2, -1, 32'h0, 1'b1);
  endtask

  task automatic test_idle_snoop();
    run_fill(32'h0000_0808, 0, 1, 4, 32'h0000_080C, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    bus.miss      = 1'b1;
    bus.miss_addr = 32'h0000_2080;
    tick();
    bus.miss    = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      bus.mem_rvalid = 1'b1;
      sample();
      checks++;
      if ({bus.data_wen, bus.data_word_idx} !== {1'b1, 2'(w)}) begin
        errors++; $display("FAIL prereset_word got wen=%b idx=%0d want 1 %0d", bus.data_wen, bus.data_word_idx, w);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    checks++;
    if (all_outs() !== 73'd0) begin
      errors++; $display("FAIL midfill_reset got %h want 0", all_outs());
    end
    tick();
    bus.mem_rvalid = 1'b0;
    word_q.delete();
    tag_q.delete();
    model_ptr = 0;
    run_fill(32'h0000_2080, 1, 0, -1, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fill();
    test_rotation();
    test_snoop_poison();
    test_snoop_tagwr();
    test_delayed_ack();
    test_idle_snoop();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
